// File: rtl/perf_log_pkg.sv
// perf_log_pkg: shared types and constants for the perf/log control block
package perf_log_pkg;
   localparam int TIMER_W = 64;
   typedef enum logic {IDLE, STREAM} snap_state_e;
endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: enabled accumulator that sticks at all-ones, with synchronous clear
module perf_sat_counter #(
   parameter int CNT_W = 48,
   parameter int INC_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum;
   always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
      cnt_d = clr_i ? '0 : !en_i ? cnt_q : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk_i) cnt_q <= rst_i ? '0 : cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/perf_log_ctrl.sv
// perf_log_ctrl: global timer, log window, dump/clean pulses, perf counters and snapshot streaming
module perf_log_ctrl
   import perf_log_pkg::*;
#(
   parameter  int NUM_CH = 8,
   parameter  int INC_W  = 6,
   parameter  int CNT_W  = 48,
   parameter  int IVL_W  = 32,
   localparam int IDX_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [TIMER_W-1:0]      cfg_log_begin,
   input  logic [TIMER_W-1:0]      cfg_log_end,
   input  logic [IVL_W-1:0]        cfg_dump_ivl,
   input  logic                    sw_dump_req,
   input  logic                    sw_clean_req,
   input  logic [NUM_CH*INC_W-1:0] perf_inc,
   output logic [TIMER_W-1:0]      timer,
   output logic                    logEnable,
   output logic                    clean,
   output logic                    dump,
   output logic                    snap_valid,
   input  logic                    snap_ready,
   output logic [IDX_W-1:0]        snap_idx,
   output logic [CNT_W-1:0]        snap_value,
   output logic                    dump_overrun
);
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               le_q, le_d, clean_q, dump_q, dump_d, ovr_q, ovr_d;
   logic [IVL_W-1:0]   ivl_cnt_q, ivl_cnt_d, ivl_q;
   logic               ivl_chg, ivl_hit, accept, last;
   snap_state_e        state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt [NUM_CH];
   logic [CNT_W-1:0]   shadow_q [NUM_CH];

   // a config change restarts the interval without firing in that cycle
   always_comb begin
      timer_d   = timer_q + TIMER_W'(1);
      le_d      = (timer_d >= cfg_log_begin) && (timer_d < cfg_log_end);
      ivl_chg   = cfg_dump_ivl != ivl_q;
      ivl_hit   = !ivl_chg && cfg_dump_ivl != '0 && ivl_cnt_q == cfg_dump_ivl - IVL_W'(1);
      ivl_cnt_d = (ivl_chg || ivl_hit || cfg_dump_ivl == '0) ? '0 : ivl_cnt_q + IVL_W'(1);
      dump_d    = sw_dump_req | ivl_hit;
   end

   always_comb begin
      accept  = state_q == STREAM && snap_ready;
      last    = idx_q == IDX_W'(NUM_CH-1);
      ovr_d   = ovr_q | (dump_q && state_q == STREAM);
      state_d = state_q == IDLE ? (dump_q ? STREAM : IDLE) : (accept && last ? IDLE : STREAM);
      idx_d   = state_q == IDLE ? '0 : accept ? (last ? '0 : idx_q + IDX_W'(1)) : idx_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         timer_q   <= '0;
         le_q      <= 1'b0;
         clean_q   <= 1'b0;
         dump_q    <= 1'b0;
         ovr_q     <= 1'b0;
         ivl_cnt_q <= '0;
         ivl_q     <= cfg_dump_ivl;
         state_q   <= IDLE;
         idx_q     <= '0;
         for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= '0;
      end else begin
         timer_q   <= timer_d;
         le_q      <= le_d;
         clean_q   <= sw_clean_req;
         dump_q    <= dump_d;
         ovr_q     <= ovr_d;
         ivl_cnt_q <= ivl_cnt_d;
         ivl_q     <= cfg_dump_ivl;
         state_q   <= state_d;
         idx_q     <= idx_d;
         // cnt[] here is still the pre-clean, pre-increment value
         if (state_q == IDLE && dump_q)
            for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= cnt[i];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      perf_sat_counter #(.CNT_W(CNT_W), .INC_W(INC_W)) u_cnt (
         .clk_i (clock),
         .rst_i (reset),
         .en_i  (le_q),
         .clr_i (clean_q),
         .inc_i (perf_inc[g*INC_W +: INC_W]),
         .cnt_o (cnt[g])
      );
   end

   assign timer        = timer_q;
   assign logEnable    = le_q;
   assign clean        = clean_q;
   assign dump         = dump_q;
   assign dump_overrun = ovr_q;
   assign snap_valid   = state_q == STREAM;
   assign snap_idx     = idx_q;
   assign snap_value   = snap_valid ? shadow_q[idx_q] : '0;
endmodule
